// File: rtl/ifetch_if.sv
// ifetch_if: memory, branch-predictor, dispatch and redirect signals of the fetch unit
interface ifetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_word;
  logic [31:0] bp_pc;
  logic [31:0] bp_inst;
  logic        bp_taken;
  logic [31:0] bp_imm;
  logic        dsp_valid;
  logic        dsp_ready;
  logic [31:0] dsp_inst;
  logic [31:0] dsp_pc;
  logic        dsp_pred_taken;
  logic [31:0] dsp_rollback_pc;
  logic        flush;
  logic [31:0] flush_pc;
  modport master (
    output mem_req, mem_addr, bp_pc, bp_inst, dsp_valid, dsp_inst, dsp_pc, dsp_pred_taken, dsp_rollback_pc,
    input  mem_done, mem_word, bp_taken, bp_imm, dsp_ready, flush, flush_pc
  );
  modport slave (
    input  mem_req, mem_addr, bp_pc, bp_inst, dsp_valid, dsp_inst, dsp_pc, dsp_pred_taken, dsp_rollback_pc,
    output mem_done, mem_word, bp_taken, bp_imm, dsp_ready, flush, flush_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: direct-mapped I-cache with word-at-a-time refill feeding a predicted-path instruction queue
module ifetch_unit #(
  parameter int ICACHE_LINES = 64,
  parameter int LINE_WORDS   = 4,
  parameter int IQ_DEPTH     = 8
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  ifetch_if.master bus
);
  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(ICACHE_LINES);
  localparam int AW = WB + IB;
  localparam int TB = 30 - AW;
  localparam int KW = WB > 0 ? WB : 1;
  localparam int QW = $clog2(IQ_DEPTH);
  typedef enum logic [1:0] {IDLE, REFILL, DRAIN} state_t;
  state_t state, state_d;
  logic [31:0] pc, rbase, addr_q, line_base, hit_word;
  logic req_q;
  logic [KW-1:0] k;
  logic [ICACHE_LINES-1:0] valid;
  logic [TB-1:0] tags [ICACHE_LINES];
  logic [31:0] data [ICACHE_LINES*LINE_WORDS];
  logic [31:0] q_inst [IQ_DEPTH];
  logic [31:0] q_pc [IQ_DEPTH];
  logic [31:0] q_rb [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] q_tk;
  logic [QW-1:0] head, tail;
  logic [QW:0] count;
  logic [IB-1:0] idx, ridx;
  logic [TB-1:0] ptag;
  logic hit, vld, deq, enq, wr, last, fill_done, miss_start, more;
  assign idx = IB'(pc >> (2 + WB));
  assign ridx = IB'(rbase >> (2 + WB));
  assign ptag = TB'(pc >> (2 + AW));
  assign line_base = pc & ~(32'(LINE_WORDS * 4) - 32'd1);
  assign hit_word = data[AW'(pc >> 2)];
  assign hit = valid[idx] && tags[idx] == ptag;
  assign vld = count != '0;
  assign deq = vld && bus.dsp_ready;
  assign enq = hit && !bus.flush && (count != (QW+1)'(IQ_DEPTH) || deq);
  assign wr = state == REFILL && bus.mem_done;
  assign last = 32'(k) == 32'(LINE_WORDS - 1);
  assign fill_done = wr && last;
  // state register; rdy low freezes the refill sequencer
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else if (rdy) state <= state_d;
  // refill sequencing: start on an idle miss, chain word requests, drain a request orphaned by a flush
  always_comb begin
    state_d = state;
    miss_start = 1'b0;
    more = 1'b0;
    case (state)
      IDLE: begin
        miss_start = !hit && !bus.flush;
        state_d = miss_start ? REFILL : IDLE;
      end
      REFILL: begin
        more = bus.mem_done && !last && !bus.flush;
        state_d = bus.mem_done ? (more ? REFILL : IDLE) : (bus.flush ? DRAIN : REFILL);
      end
      DRAIN: state_d = bus.mem_done ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // pc steering, memory request pulse/address, word counter and line valid bits
  always_ff @(posedge clk)
    if (rst) begin
      pc <= '0;
      rbase <= '0;
      addr_q <= '0;
      req_q <= 1'b0;
      k <= '0;
      valid <= '0;
    end else if (rdy) begin
      req_q <= miss_start || more;
      pc <= bus.flush ? bus.flush_pc : enq ? pc + (bus.bp_taken ? bus.bp_imm : 32'd4) : pc;
      if (miss_start) begin
        rbase <= line_base;
        addr_q <= line_base;
        k <= '0;
        valid[idx] <= 1'b0;
      end
      if (more) begin
        k <= k + KW'(1);
        addr_q <= addr_q + 32'd4;
      end
      if (fill_done) valid[ridx] <= 1'b1;
    end
  // queue pointers; a flush empties the queue outright
  always_ff @(posedge clk)
    if (rst || (rdy && bus.flush)) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (rdy) begin
      head <= head + QW'(deq);
      tail <= tail + QW'(enq);
      count <= count + (QW+1)'(enq) - (QW+1)'(deq);
    end
  // cache tag/data and queue payload storage, no reset needed behind the valid bits and count
  always_ff @(posedge clk)
    if (!rst && rdy) begin
      if (miss_start) tags[idx] <= ptag;
      if (wr) data[AW'((rbase >> 2) + 32'(k))] <= bus.mem_word;
      if (enq) begin
        q_inst[tail] <= hit_word;
        q_pc[tail] <= pc;
        q_tk[tail] <= bus.bp_taken;
        q_rb[tail] <= pc + 32'd4;
      end
    end
  assign bus.mem_req = req_q;
  assign bus.mem_addr = addr_q;
  assign bus.bp_pc = pc;
  assign bus.bp_inst = hit ? hit_word : '0;
  assign bus.dsp_valid = vld;
  assign bus.dsp_inst = vld ? q_inst[head] : '0;
  assign bus.dsp_pc = vld ? q_pc[head] : '0;
  assign bus.dsp_pred_taken = vld && q_tk[head];
  assign bus.dsp_rollback_pc = vld ? q_rb[head] : '0;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scenario tests plus a randomized run checked against a program-order fetch model
module tb_ifetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  ifetch_if bus();
  ifetch_unit dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
  initial forever #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int ndisp = 0;
  int pmode = 0;
  int lat_lo = 1;
  int lat_hi = 1;
  logic tk_tab [256];
  logic [31:0] im_tab [256];
  logic [31:0] exp_pc = 0;
  logic m_pend = 1'b0;
  logic m_req_prev = 1'b0;
  logic [31:0] m_a_prev = 0;
  logic [31:0] m_paddr = 0;
  int m_lat = 0;
  function automatic logic ptk(input logic [31:0] p);
    return pmode == 1 ? p == 32'h10 : pmode == 2 ? tk_tab[p[9:2]] : 1'b0;
  endfunction
  function automatic logic [31:0] pimm(input logic [31:0] p);
    return pmode == 1 ? 32'hFFFF_FFF8 : pmode == 2 ? im_tab[p[9:2]] : 32'd0;
  endfunction
  always_comb begin
    bus.bp_taken = ptk(bus.bp_pc);
    bus.bp_imm = pimm(bus.bp_pc);
  end
  initial begin
    bus.mem_done = 1'b0;
    bus.mem_word = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_pend = 1'b0;
        bus.mem_done = 1'b0;
      end else if (rdy) begin
        if (bus.mem_done) bus.mem_done = 1'b0;
        if (m_req_prev) begin
          total++;
          if (m_pend || m_a_prev[1:0] != 2'b00) begin
            bad++;
            $display("FAIL mem_request addr=%h pending=%b required no pending request and aligned addr", m_a_prev, m_pend);
          end
          m_pend = 1'b1;
          m_paddr = m_a_prev;
          m_lat = $urandom_range(lat_hi, lat_lo);
        end else if (m_pend) begin
          if (m_lat == 0) begin
            bus.mem_done = 1'b1;
            bus.mem_word = m_paddr + 32'h13;
            m_pend = 1'b0;
          end else m_lat--;
        end
      end
      m_req_prev = bus.mem_req;
      m_a_prev = bus.mem_addr;
    end
  end
  initial forever begin
    @(negedge clk);
    #1;
    if (rst) exp_pc = 0;
    else if (rdy) begin
      if (bus.flush) exp_pc = bus.flush_pc;
      else if (bus.dsp_valid && bus.dsp_ready) begin
        total++;
        if (bus.dsp_pc !== exp_pc || bus.dsp_inst !== exp_pc + 32'h13 || bus.dsp_rollback_pc !== exp_pc + 32'd4 || bus.dsp_pred_taken !== ptk(exp_pc)) begin
          bad++;
          $display("FAIL dispatch pc=%h inst=%h rb=%h tk=%b required pc=%h inst=%h rb=%h tk=%b", bus.dsp_pc, bus.dsp_inst, bus.dsp_rollback_pc, bus.dsp_pred_taken, exp_pc, exp_pc + 32'h13, exp_pc + 32'd4, ptk(exp_pc));
        end
        exp_pc = ptk(exp_pc) ? exp_pc + pimm(exp_pc) : exp_pc + 32'd4;
        ndisp++;
      end
    end
  end
  task automatic do_reset(input int m);
    rst = 1'b1;
    rdy = 1'b1;
    bus.dsp_ready = 1'b0;
    bus.flush = 1'b0;
    pmode = m;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset;
    logic [31:0] got [8];
    string nm [8];
    rst = 1'b1;
    rdy = 1'b0;
    repeat (3) @(negedge clk);
    got = '{32'(bus.mem_req), bus.mem_addr, bus.bp_pc, 32'(bus.dsp_valid), bus.dsp_inst, bus.dsp_pc, 32'(bus.dsp_pred_taken), bus.dsp_rollback_pc};
    nm = '{"mem_req", "mem_addr", "bp_pc", "dsp_valid", "dsp_inst", "dsp_pc", "dsp_pred_taken", "dsp_rollback_pc"};
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got[i] !== 32'd0) begin
        bad++;
        $display("FAIL reset_%s got=%h required=0", nm[i], got[i]);
      end
    end
    rst = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
    total++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0 || bus.dsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_miss req=%b addr=%h valid=%b required 1 0 0", bus.mem_req, bus.mem_addr, bus.dsp_valid);
    end
  endtask
  task automatic test_refill;
    logic [31:0] reqs [$];
    logic [31:0] pcs [$];
    logic [31:0] insts [$];
    lat_lo = 1;
    lat_hi = 1;
    do_reset(0);
    bus.dsp_ready = 1'b1;
    for (int c = 0; c < 100 && pcs.size() < 4; c++) begin
      if (bus.mem_req) reqs.push_back(bus.mem_addr);
      if (bus.dsp_valid) begin
        pcs.push_back(bus.dsp_pc);
        insts.push_back(bus.dsp_inst);
      end
      @(negedge clk);
    end
    total++;
    if (pcs.size() != 4 || reqs.size() < 4) begin
      bad++;
      $display("FAIL refill_timeout dispatched=%0d requests=%0d required 4 and at least 4", pcs.size(), reqs.size());
    end else
      for (int i = 0; i < 4; i++) begin
        total++;
        if (reqs[i] !== 32'(4 * i) || pcs[i] !== 32'(4 * i) || insts[i] !== 32'(4 * i + 32'h13)) begin
          bad++;
          $display("FAIL refill_word%0d req=%h pc=%h inst=%h required %h %h %h", i, reqs[i], pcs[i], insts[i], 4 * i, 4 * i, 4 * i + 32'h13);
        end
      end
  endtask
  task automatic test_full;
    for (int c = 0; c < 300 && bus.bp_pc != 32'h30; c++) @(negedge clk);
    total++;
    if (bus.bp_pc !== 32'h30) begin
      bad++;
      $display("FAIL full_warmup bp_pc=%h required=00000030", bus.bp_pc);
    end
    bus.flush = 1'b1;
    bus.flush_pc = 32'h0;
    bus.dsp_ready = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    repeat (15) @(negedge clk);
    total++;
    if (bus.bp_pc !== 32'h20 || bus.dsp_valid !== 1'b1 || bus.dsp_pc !== 32'h0) begin
      bad++;
      $display("FAIL full_stall bp_pc=%h valid=%b dsp_pc=%h required 00000020 1 00000000", bus.bp_pc, bus.dsp_valid, bus.dsp_pc);
    end
    bus.dsp_ready = 1'b1;
    @(negedge clk);
    bus.dsp_ready = 1'b0;
    total++;
    if (bus.bp_pc !== 32'h24 || bus.dsp_pc !== 32'h4) begin
      bad++;
      $display("FAIL full_swap bp_pc=%h dsp_pc=%h required 00000024 00000004", bus.bp_pc, bus.dsp_pc);
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.bp_pc !== 32'h24) begin
      bad++;
      $display("FAIL full_count_held bp_pc=%h required=00000024", bus.bp_pc);
    end
    bus.dsp_ready = 1'b1;
    repeat (20) @(negedge clk);
  endtask
  task automatic test_branch;
    logic [31:0] pcs [$];
    logic [31:0] rbs [$];
    logic tks [$];
    logic [31:0] p;
    lat_lo = 1;
    lat_hi = 3;
    do_reset(1);
    bus.dsp_ready = 1'b1;
    for (int c = 0; c < 300 && pcs.size() < 8; c++) begin
      if (bus.dsp_valid) begin
        pcs.push_back(bus.dsp_pc);
        rbs.push_back(bus.dsp_rollback_pc);
        tks.push_back(bus.dsp_pred_taken);
      end
      @(negedge clk);
    end
    total++;
    if (pcs.size() != 8) begin
      bad++;
      $display("FAIL branch_timeout dispatched=%0d required=8", pcs.size());
    end else begin
      p = 32'h0;
      for (int i = 0; i < 8; i++) begin
        total++;
        if (pcs[i] !== p || tks[i] !== (p == 32'h10) || rbs[i] !== p + 32'd4) begin
          bad++;
          $display("FAIL branch_entry%0d pc=%h tk=%b rb=%h required %h %b %h", i, pcs[i], tks[i], rbs[i], p, p == 32'h10, p + 32'd4);
        end
        p = p == 32'h10 ? p - 32'd8 : p + 32'd4;
      end
    end
  endtask
  task automatic test_flush_drain;
    logic saw_done, got;
    logic [31:0] first_addr;
    lat_lo = 6;
    lat_hi = 6;
    do_reset(0);
    bus.dsp_ready = 1'b1;
    for (int c = 0; c < 100 && !(bus.mem_req && bus.mem_addr == 32'h4); c++) @(negedge clk);
    total++;
    if (!(bus.mem_req && bus.mem_addr == 32'h4)) begin
      bad++;
      $display("FAIL drain_second_req req=%b addr=%h required 1 00000004", bus.mem_req, bus.mem_addr);
    end
    @(negedge clk);
    bus.flush = 1'b1;
    bus.flush_pc = 32'h100;
    @(negedge clk);
    bus.flush = 1'b0;
    total++;
    if (bus.dsp_valid !== 1'b0 || bus.bp_pc !== 32'h100 || bus.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL drain_flush valid=%b bp_pc=%h req=%b required 0 00000100 0", bus.dsp_valid, bus.bp_pc, bus.mem_req);
    end
    saw_done = 1'b0;
    got = 1'b0;
    first_addr = '0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (bus.mem_done) saw_done = 1'b1;
      if (bus.mem_req) begin
        got = 1'b1;
        first_addr = bus.mem_addr;
      end else @(negedge clk);
    end
    total++;
    if (!got || first_addr !== 32'h100 || !saw_done) begin
      bad++;
      $display("FAIL drain_restart seen=%b addr=%h drained=%b required 1 00000100 1", got, first_addr, saw_done);
    end
    for (int c = 0; c < 100 && !(bus.dsp_valid && bus.dsp_pc == 32'h100); c++) @(negedge clk);
    bus.flush = 1'b1;
    bus.flush_pc = 32'h0;
    @(negedge clk);
    bus.flush = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (bus.mem_req && bus.mem_addr == 32'h0) got = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL drain_line_invalid refetch_of_0=%b required=1", got);
    end
  endtask
  task automatic test_freeze;
    logic got;
    logic [31:0] a;
    int n0;
    lat_lo = 10;
    lat_hi = 10;
    do_reset(0);
    bus.dsp_ready = 1'b1;
    for (int c = 0; c < 20 && !bus.mem_req; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus.bp_pc !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_req !== 1'b0 || bus.dsp_valid !== 1'b0 || bus.dsp_pc !== 32'h0) begin
        bad++;
        $display("FAIL freeze_cycle%0d bp_pc=%h addr=%h req=%b valid=%b dsp_pc=%h required all zero", i, bus.bp_pc, bus.mem_addr, bus.mem_req, bus.dsp_valid, bus.dsp_pc);
      end
    end
    rdy = 1'b1;
    n0 = ndisp;
    got = 1'b0;
    a = '0;
    for (int c = 0; c < 60 && !got; c++) begin
      if (bus.mem_req) begin
        got = 1'b1;
        a = bus.mem_addr;
      end else @(negedge clk);
    end
    total++;
    if (!got || a !== 32'h4) begin
      bad++;
      $display("FAIL freeze_resume_req seen=%b addr=%h required 1 00000004", got, a);
    end
    for (int c = 0; c < 200 && ndisp < n0 + 4; c++) @(negedge clk);
    total++;
    if (ndisp < n0 + 4) begin
      bad++;
      $display("FAIL freeze_resume_dispatch count=%0d required>=4", ndisp - n0);
    end
  endtask
  task automatic test_random;
    int v, n0;
    for (int i = 0; i < 256; i++) begin
      tk_tab[i] = $urandom_range(7, 0) == 0;
      v = $urandom_range(32, 0);
      if (v == 16) v = 17;
      im_tab[i] = 32'(v - 16) << 2;
    end
    lat_lo = 0;
    lat_hi = 4;
    do_reset(2);
    n0 = ndisp;
    for (int c = 0; c < 3000; c++) begin
      bus.dsp_ready = $urandom_range(9, 0) < 7;
      rdy = $urandom_range(19, 0) != 0;
      bus.flush = $urandom_range(99, 0) == 0;
      bus.flush_pc = 32'($urandom_range(255, 0)) << 2;
      @(negedge clk);
    end
    bus.flush = 1'b0;
    rdy = 1'b1;
    total++;
    if (ndisp - n0 < 300) begin
      bad++;
      $display("FAIL random_progress dispatched=%0d required>=300", ndisp - n0);
    end
  endtask
  initial begin
    bus.dsp_ready = 1'b0;
    bus.flush = 1'b0;
    bus.flush_pc = '0;
    @(negedge clk);
    test_reset();
    test_refill();
    test_full();
    test_branch();
    test_flush_drain();
    test_freeze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter ICACHE_LINES, default 64, number of direct-mapped I-cache lines (power of 2, >=2).
REQ-002 Parameter LINE_WORDS, default 4, 32-bit words per cache line (power of 2, >=1).
REQ-003 Parameter IQ_DEPTH, default 8, instruction-queue entries (power of 2, >=2).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rdy  in  1  global enable; low = freeze all state, hold all outputs.
REQ-007 mem_req  out  1  one-cycle pulse requesting one word from the memory controller.
REQ-008 mem_addr  out  32  word address of the request; held stable until mem_done.
REQ-009 mem_done  in  1  one-cycle pulse; mem_word valid this cycle.
REQ-010 mem_word  in  32  returned instruction word.
REQ-011 bp_pc / bp_inst  out  32 / 32  current pc and hit instruction (zero on miss) to branch predictor.
REQ-012 bp_taken / bp_imm  in  1 / 32  predictor result for bp_pc, combinational, same cycle.
REQ-013 dsp_valid  out  1  queue head valid (queue non-empty).
REQ-014 dsp_ready  in  1  dispatcher accepts head this cycle.
REQ-015 dsp_inst / dsp_pc / dsp_pred_taken / dsp_rollback_pc  out  32/32/1/32  head-entry fields.
REQ-016 flush / flush_pc  in  1 / 32  misbranch redirect from ROB.

Function
REQ-017 Address split: offset = pc[1:0] (ignored); word = next log2(LINE_WORDS) bits; index = next log2(ICACHE_LINES) bits; tag = remaining upper bits.
REQ-018 Hit = valid[index] and tag[index] equals pc tag field; evaluated combinationally on current pc.
REQ-019 Enqueue condition: hit, state IDLE or REFILL-of-other-line irrelevant (hit only), no flush, and (count < IQ_DEPTH or dequeue this cycle).
REQ-020 On enqueue: entry = {line word, pc, bp_taken, pc+4}; pc <= bp_taken ? pc+bp_imm : pc+4 (32-bit wrap).
REQ-021 Enqueued entry appears on dsp_* the cycle after enqueue at earliest (1-cycle hit latency).
REQ-022 Dequeue when dsp_valid and dsp_ready; head pointer advances; pointers wrap modulo IQ_DEPTH.
REQ-023 Simultaneous enqueue and dequeue with queue full: both occur, count unchanged.
REQ-024 FSM states IDLE, REFILL, DRAIN.
REQ-025 IDLE, miss, no flush: clear valid[index], latch line base, word counter k=0, pulse mem_req with mem_addr = base, go REFILL.
REQ-026 REFILL, mem_done: write mem_word to word k; if k = LINE_WORDS-1 set valid and tag, go IDLE; else k<=k+1, pulse mem_req next-word address in same edge.
REQ-027 At most one memory request outstanding at any time.
REQ-028 Flush (any state): queue emptied (count 0), pc <= flush_pc, no enqueue that cycle; flush has priority over all other events.
REQ-029 Flush in REFILL with request outstanding and no mem_done that cycle: go DRAIN; line stays invalid.
REQ-030 Flush coinciding with mem_done in REFILL: word written as REQ-026, then state IDLE, line valid only if it was the last word.
REQ-031 DRAIN: ignore hits-to-refill logic, allow hits/enqueue; on mem_done discard word, go IDLE; no mem_req issued.
REQ-032 Hits on other lines during REFILL are enqueued normally (hit-under-miss).

Reset
REQ-033 On rst: state IDLE, pc=0, k=0, queue empty, all valid bits 0, mem_req=0, mem_addr=0, dsp_valid=0, dsp_* data=0.
REQ-034 rst dominates rdy; rst mid-refill abandons the refill; a late mem_done after reset is ignored.

Verification
REQ-035 Reset, dsp_ready=1, memory returns word=addr+0x13 after 2 cycles -> mem_req at 0x0,0x4,0x8,0xC, then dsp_pc 0x0,0x4,0x8,0xC in order with dsp_inst 0x13,0x17,0x1B,0x1F.
REQ-036 dsp_ready=0, lines 0x0-0x1F cached -> exactly 8 enqueues, pc stops at 0x20; then dsp_ready=1 for one cycle -> one dequeue and one enqueue same cycle, count stays 8.
REQ-037 At pc 0x10 bp_taken=1, bp_imm=0xFFFFFFF8 -> entry dsp_pred_taken=1, dsp_rollback_pc=0x14; next fetched pc 0x08.
REQ-038 Flush flush_pc=0x100 while 2nd refill word outstanding -> DRAIN, queue empty, returning word discarded, line invalid, then new refill starting mem_addr 0x100.
REQ-039 rdy=0 for 5 cycles mid-refill with mem_done held low -> pc, queue, k, outputs unchanged; resume correctly on rdy=1.
